msg_scroller: RTL and testbench
===============================

Name: msg_scroller

Overview:
Upstream character source for the scrolling 7-segment display. It replaces the fixed counter-plus-message-ROM pair with a writable message buffer, a variable message length, and a configurable blank gap between repetitions. On each scroll tick it presents one 5-bit character code to strTo7seg, which feeds the segment shift-register chain. Q changes on the same CLK edge on which the shift registers capture, so the chain always samples the previous code.

Parameters:
DEPTH, 16, number of character slots in the message buffer
AW, 4, buffer address width; must satisfy 2**AW >= DEPTH
CW, 5, character code width; must match the strTo7seg input width
GAP, 6, number of blank characters inserted after each message pass; 0 means no gap

Ports:
CLK  in  1  system clock (50 MHz)
RST  in  1  synchronous, active-high reset
EN  in  1  scroll tick from the prescaler, one CLK cycle wide
RUN  in  1  level input; 1 = scroll, 0 = freeze (EN ignored)
WR_EN  in  1  buffer write strobe
WR_ADDR  in  AW  buffer write address
WR_DATA  in  CW  character code to write
LEN  in  AW+1  message length 0..DEPTH; values above DEPTH are clamped to DEPTH; sampled only at message start
Q  out  CW  current character code, registered
SOM  out  1  start-of-message pulse, one CLK cycle wide
BUSY  out  1  high when state is MSG or GAP

Behaviour:
- Step = rising CLK edge with EN=1, RUN=1, RST=0. All state and Q changes happen only on steps, except buffer writes and SOM clear.
- Reset: state=IDLE, Q=CHAR_BLANK, SOM=0, BUSY=0, idx=0, gcnt=0, len_q=0. Reset does not clear buffer contents. RST has priority over EN and WR_EN.
- Buffer: DEPTH x CW. Synchronous write on any cycle with WR_EN=1. Writes to WR_ADDR >= DEPTH are ignored. Reads are read-before-write: a step and a write to the same address on the same edge load the old data into Q.
- "Wrap" action: len_q <= min(LEN, DEPTH).
  - If the new len_q is 0: state=IDLE, Q=CHAR_BLANK.
  - Otherwise: state=MSG, idx=0, Q=mem[0], SOM=1 on the next cycle.
- IDLE: on a step, perform wrap. Otherwise hold Q=CHAR_BLANK.
- MSG, on a step:
  - If idx < len_q-1: idx++, Q=mem[idx+1].
  - Else if GAP>0: state=GAP, gcnt=1, Q=CHAR_BLANK.
  - Else: wrap.
- GAP, on a step:
  - If gcnt==GAP: wrap.
  - Else: gcnt++, Q=CHAR_BLANK.
- A change on LEN takes effect only at wrap. The current pass always completes with the latched len_q.
- SOM is high exactly one CLK cycle after each wrap that enters MSG. It is 0 at all other times.
- RUN=0 freezes state, idx, gcnt and Q indefinitely. Writes still occur.
- Latency: Q is valid in the cycle after the step edge. There is no handshake; the block is tick-driven only.

Decomposition:
- Package msg_pkg holds:
  - CHAR_BLANK = 5'd31, shared with strTo7seg, where code 31 maps to all segments off.
  - State encoding: IDLE=2'd0, MSG=2'd1, GAP=2'd2.
- One natural sub-module: msg_buffer, the DEPTH x CW single-write, single-read RAM with read-before-write behaviour. The FSM, the idx/gcnt counters and the Q register stay in msg_scroller.

Test Plan:
1. Reset; write codes 1,2,3,4,5 to addresses 0..4; LEN=5, GAP=2, RUN=1; 10 EN pulses -> Q = 1,2,3,4,5,31,31,1,2,3; SOM high after steps 1 and 8 only; BUSY=1 from step 1 onward.
2. Same setup with GAP=0 instance, 7 steps -> Q = 1,2,3,4,5,1,2; SOM after steps 1 and 6.
3. LEN=0, 5 steps -> Q stays 31, SOM never asserts, BUSY=0. Then set LEN=20 -> len_q clamps to 16 and 16 steps walk addresses 0..15.
4. LEN changed 5->3 while idx=1 -> pass finishes 2,3,4,5, then gap, then 1,2,3,31,...; RUN=0 for 4 EN pulses mid-pass -> Q unchanged throughout.
5. WR_EN to address 2 with data 9 on the same edge as the step that reads address 2 -> Q=3 (old data); the next pass shows 9 at that position.
6. RST pulsed during GAP -> next cycle Q=31, state IDLE, SOM=0; buffer intact, so the next step outputs 1 with SOM.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared definitions for the scrolling message source.
//   CHAR_BLANK : character code that strTo7seg renders with all segments off
//   state_e    : scroller FSM state encoding
package msg_pkg;

    localparam logic [4:0] CHAR_BLANK = 5'd31;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMsg  = 2'd1,
        StGap  = 2'd2
    } state_e;

endpackage

// File: rtl/msg_buffer.sv
// Message character buffer: DEPTH x CW RAM, one synchronous write port and one
// combinational read port. Because the read is combinational and the consumer
// registers it, a read and a write to the same address on one edge return the
// old contents (read-before-write).
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address; addresses >= DEPTH are ignored
//   wr_data : write data
//   rd_addr : read address
//   rd_data : contents at rd_addr (zero when rd_addr >= DEPTH)
module msg_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned CW    = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [CW-1:0] mem [DEPTH];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok = {1'b0, rd_addr} < DEPTH_L;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolling message character source. On each scroll step (EN && RUN) it
// presents the next character of the stored message on Q, followed by GAP
// blank characters, then starts the message again with a SOM pulse.
// Ports:
//   CLK     : system clock
//   RST     : synchronous active-high reset (buffer contents are kept)
//   EN      : one-cycle scroll tick
//   RUN     : 1 = scroll, 0 = freeze
//   WR_EN   : buffer write strobe
//   WR_ADDR : buffer write address
//   WR_DATA : character code to write
//   LEN     : message length, clamped to DEPTH, sampled at message start
//   Q       : current character code (registered)
//   SOM     : one-cycle start-of-message pulse
//   BUSY    : high while scrolling the message or its gap
module msg_scroller #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned CW    = 5,
    parameter int unsigned GAP   = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          RUN,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [CW-1:0] WR_DATA,
    input  logic [AW:0]   LEN,
    output logic [CW-1:0] Q,
    output logic          SOM,
    output logic          BUSY
);

    import msg_pkg::*;

    localparam logic [CW-1:0] BLANK   = CW'(CHAR_BLANK);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW + 1)'(1);
    // At least one bit so the counter exists even when GAP is 0.
    localparam int unsigned   GW      = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_L   = GW'(GAP);

    state_e        state_q;
    logic [AW-1:0] idx_q;
    logic [GW-1:0] gcnt_q;
    logic [AW:0]   len_q;
    logic [CW-1:0] q_q;
    logic          som_q;
    logic          busy_q;

    logic          step;
    logic          more;
    logic          wrap;
    logic [AW:0]   len_clamp;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          buf_we;

    // Reset blocks writes so RST takes priority over WR_EN.
    assign buf_we = WR_EN && !RST;

    msg_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_buffer (
        .clk     (CLK),
        .wr_en   (buf_we),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        step      = EN && RUN;
        len_clamp = (LEN > DEPTH_L) ? DEPTH_L : LEN;
        idx_inc   = idx_q + AW'(1);
        // idx < len_q - 1 written without subtraction so len_q = 0 is safe.
        more      = ({1'b0, idx_q} + ONE_L) < len_q;
        // Read address is 0 unless advancing within the message, so a wrap
        // always sees mem[0] on rd_data.
        rd_addr   = (state_q == StMsg && more) ? idx_inc : '0;
        wrap      = 1'b0;
        if (step) begin
            unique case (state_q)
                StIdle:  wrap = 1'b1;
                StMsg:   wrap = !more && (GAP == 0);
                StGap:   wrap = (gcnt_q == GAP_L);
                default: wrap = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gcnt_q  <= '0;
            len_q   <= '0;
            q_q     <= BLANK;
            som_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            som_q <= 1'b0;
            if (wrap) begin
                len_q <= len_clamp;
                if (len_clamp == '0) begin
                    state_q <= StIdle;
                    q_q     <= BLANK;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= StMsg;
                    idx_q   <= '0;
                    q_q     <= rd_data;
                    som_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
            end else if (step) begin
                unique case (state_q)
                    StMsg: begin
                        if (more) begin
                            idx_q <= idx_inc;
                            q_q   <= rd_data;
                        end else begin
                            state_q <= StGap;
                            gcnt_q  <= GW'(1);
                            q_q     <= BLANK;
                        end
                    end
                    StGap: begin
                        gcnt_q <= gcnt_q + GW'(1);
                        q_q    <= BLANK;
                    end
                    default: begin
                        state_q <= StIdle;
                        q_q     <= BLANK;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q    = q_q;
    assign SOM  = som_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_msg_scroller.sv
module tb_msg_scroller;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       RUN;
    logic       WR_EN;
    logic [3:0] WR_ADDR;
    logic [4:0] WR_DATA;
    logic [4:0] LEN;
    logic [4:0] q0, q2;
    logic       som0, som2, busy0, busy2;

    int errors = 0;
    int checks = 0;

    // Reference model: one position counter per pass (message slots then gap
    // slots), index 0 models the GAP=0 instance, index 1 the GAP=2 instance.
    int mem_m [16];
    int gap_m [2] = '{0, 2};
    int pos_m [2];
    int len_m [2];
    int q_m   [2];
    int som_m [2];

    msg_scroller #(.DEPTH(16), .AW(4), .CW(5), .GAP(0)) dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .RUN(RUN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .LEN(LEN), .Q(q0), .SOM(som0), .BUSY(busy0)
    );

    msg_scroller #(.DEPTH(16), .AW(4), .CW(5), .GAP(2)) dut2 (
        .CLK(CLK), .RST(RST), .EN(EN), .RUN(RUN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .LEN(LEN), .Q(q2), .SOM(som2), .BUSY(busy2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            som_m[i] = 0;
            if (RST) begin
                pos_m[i] = -1;
                q_m[i]   = 31;
            end else if (EN && RUN) begin
                if (pos_m[i] < 0 || pos_m[i] == len_m[i] + gap_m[i] - 1) begin
                    len_m[i] = (LEN > 16) ? 16 : int'(LEN);
                    if (len_m[i] == 0) begin
                        pos_m[i] = -1;
                        q_m[i]   = 31;
                    end else begin
                        pos_m[i] = 0;
                        q_m[i]   = mem_m[0];
                        som_m[i] = 1;
                    end
                end else begin
                    pos_m[i] = pos_m[i] + 1;
                    q_m[i]   = (pos_m[i] < len_m[i]) ? mem_m[pos_m[i]] : 31;
                end
            end
        end
        // Writes land after the read above: read-before-write.
        if (!RST && WR_EN) mem_m[WR_ADDR] = int'(WR_DATA);
    endtask

    task automatic cyc(input bit rst, input bit en, input bit we,
                       input logic [3:0] wa, input logic [4:0] wd);
        RST = rst; EN = en; WR_EN = we; WR_ADDR = wa; WR_DATA = wd;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        RST = 1'b0; EN = 1'b0; WR_EN = 1'b0;
        check("g0_q", q0, q_m[0]);
        check("g0_som", som0, som_m[0]);
        check("g0_busy", busy0, pos_m[0] >= 0);
        check("g2_q", q2, q_m[1]);
        check("g2_som", som2, som_m[1]);
        check("g2_busy", busy2, pos_m[1] >= 0);
    endtask

    task automatic step();
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 5'd0);
    endtask

    task automatic reset();
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 5'd0);
    endtask

    initial begin
        int exp1 [10] = '{1, 2, 3, 4, 5, 31, 31, 1, 2, 3};
        int exp2 [7]  = '{1, 2, 3, 4, 5, 1, 2};
        int exp4 [8]  = '{4, 5, 31, 31, 1, 2, 3, 31};
        RST = 1'b0; EN = 1'b0; RUN = 1'b1; WR_EN = 1'b0;
        WR_ADDR = '0; WR_DATA = '0; LEN = 5'd5;
        for (int i = 0; i < 16; i++) mem_m[i] = 0;
        for (int i = 0; i < 2; i++) begin
            pos_m[i] = -1; len_m[i] = 0; q_m[i] = 31; som_m[i] = 0;
        end

        // Reset state, then load codes i+1 at address i.
        reset();
        reset();
        check("rst_q", q2, 31);
        check("rst_busy", busy2, 0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), 5'(i + 1));

        // Test 1/2: basic pass with and without a gap.
        for (int k = 0; k < 10; k++) begin
            step();
            check("t1_q", q2, exp1[k]);
            check("t1_som", som2, (k == 0 || k == 7));
            check("t1_busy", busy2, 1);
            if (k < 7) check("t2_q", q0, exp2[k]);
            if (k < 7) check("t2_som", som0, (k == 0 || k == 5));
        end

        // Test 3: zero length stays idle, oversized length clamps to 16.
        reset();
        LEN = 5'd0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_idle_q", q2, 31);
            check("t3_idle_busy", busy2, 0);
            check("t3_idle_som", som2, 0);
        end
        LEN = 5'd20;
        for (int k = 0; k < 16; k++) begin
            step();
            check("t3_walk_q", q2, k + 1);
        end
        step();
        check("t3_gap_q", q2, 31);

        // Test 4: LEN change mid-pass, then freeze.
        reset();
        LEN = 5'd5;
        step();
        step();
        LEN = 5'd3;
        step();
        check("t4_q3", q2, 3);
        RUN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_frozen_q", q2, 3);
        end
        RUN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t4_q", q2, exp4[k]);
        end

        // Test 5: write on the same edge as the read of that address.
        reset();
        LEN = 5'd5;
        step();
        step();
        cyc(1'b0, 1'b1, 1'b1, 4'd2, 5'd9);
        check("t5_old_q", q2, 3);
        for (int k = 0; k < 7; k++) step();
        check("t5_new_q", q2, 9);

        // Test 6: reset during the gap keeps the buffer.
        reset();
        for (int k = 0; k < 6; k++) step();
        check("t6_in_gap_q", q2, 31);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 5'd0);
        check("t6_rst_q", q2, 31);
        check("t6_rst_som", som2, 0);
        check("t6_rst_busy", busy2, 0);
        step();
        check("t6_restart_q", q2, 1);
        check("t6_restart_som", som2, 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            RUN = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) LEN = 5'($urandom_range(0, 20));
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
